// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: frame geometry, CRC-8 polynomial, FSM states and default bus timing.
// The timing defaults are shared with the slave-side sampler.
package onewire_pkg;

  localparam int FRAME_W = 64;
  localparam int CMD_W   = 56;
  localparam int CRC_W   = 8;

  // Reflected form of x^8+x^5+x^4+1 (Dallas/Maxim)
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h8C;

  localparam int DEF_RESET_LOW   = 480;
  localparam int DEF_RESET_HIGH  = 410;
  localparam int DEF_PRES_SAMPLE = 70;
  localparam int DEF_SLOT        = 70;
  localparam int DEF_LOW1        = 6;
  localparam int DEF_LOW0        = 60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC,
    ST_RST_LOW,
    ST_RST_HIGH,
    ST_SLOT,
    ST_DONE
  } ow_state_t;

  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic             din);
    logic fb;
    fb = crc[0] ^ din;
    return (crc >> 1) ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/onewire_crc8_serial.sv
// Bit-serial Dallas/Maxim CRC-8: one data bit per enabled cycle, LSB-first stream, init 0x00.
// Clear has priority over enable; the result is available the cycle after the last bit.
module onewire_crc8_serial
  import onewire_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc8_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/onewire_tx.sv
// 1-Wire master transmitter: CRC over the command, bus reset, optional presence check, 64 write slots.
// Presence check and abort are built only with ONEWIRE_TX_PRESENCE_CHECK_EN defined.
module onewire_tx
  import onewire_pkg::*;
#(
  parameter int RESET_LOW   = DEF_RESET_LOW,
  parameter int RESET_HIGH  = DEF_RESET_HIGH,
  parameter int PRES_SAMPLE = DEF_PRES_SAMPLE,
  parameter int SLOT        = DEF_SLOT,
  parameter int LOW1        = DEF_LOW1,
  parameter int LOW0        = DEF_LOW0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] i_command,
  input  logic             i_start,
  inout  wire              bus,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_no_presence
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] C_RST_LOW_END  = CNT_W'(RESET_LOW - 1);
  localparam logic [CNT_W-1:0] C_RST_HIGH_END = CNT_W'(RESET_HIGH - 1);
  localparam logic [CNT_W-1:0] C_SLOT_END     = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] C_LOW1         = CNT_W'(LOW1);
  localparam logic [CNT_W-1:0] C_LOW0         = CNT_W'(LOW0);
  localparam logic [5:0]       C_CMD_LAST     = 6'(CMD_W - 1);
  localparam logic [5:0]       C_FRAME_LAST   = 6'(FRAME_W - 1);

  if (!(LOW1 < LOW0 && LOW0 < SLOT && PRES_SAMPLE < RESET_HIGH)) begin : g_bad_params
    $error("onewire_tx: illegal timing parameters");
  end

  ow_state_t          r_state;
  logic [CMD_W-1:0]   r_cmd;
  logic [CNT_W-1:0]   r_cnt;
  logic [5:0]         r_bit;
  logic               r_drive_low;
  logic               r_busy;
  logic               r_done;

  logic [CRC_W-1:0]   w_crc;
  logic [FRAME_W-1:0] w_frame;
  logic               w_crc_clr;
  logic               w_crc_en;
  logic               w_crc_bit;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_low_len;

  assign w_crc_clr = (r_state == ST_IDLE) && i_start;
  assign w_crc_en  = (r_state == ST_CRC);
  assign w_crc_bit = r_cmd[r_bit];
  assign w_frame   = {w_crc, r_cmd};
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_low_len = w_frame[r_bit] ? C_LOW1 : C_LOW0;

  onewire_crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (w_crc_bit),
    .o_crc (w_crc)
  );

`ifdef ONEWIRE_TX_PRESENCE_CHECK_EN
  logic [1:0] r_sync;
  logic       r_no_presence;

  // Reset to released (1) so a reset never looks like a presence pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus};
    end
  end

  assign o_no_presence = r_no_presence;
`else
  assign o_no_presence = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_drive_low <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef ONEWIRE_TX_PRESENCE_CHECK_EN
      r_no_presence <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done      <= 1'b0;
          r_drive_low <= 1'b0;
          if (i_start) begin
            r_cmd   <= i_command;
            r_busy  <= 1'b1;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_state <= ST_CRC;
`ifdef ONEWIRE_TX_PRESENCE_CHECK_EN
            r_no_presence <= 1'b0;
`endif
          end
        end

        ST_CRC: begin
          if (r_bit == C_CMD_LAST) begin
            r_bit       <= '0;
            r_cnt       <= '0;
            r_drive_low <= 1'b1;
            r_state     <= ST_RST_LOW;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end

        ST_RST_LOW: begin
          if (r_cnt == C_RST_LOW_END) begin
            r_cnt       <= '0;
            r_drive_low <= 1'b0;
            r_state     <= ST_RST_HIGH;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end

        ST_RST_HIGH: begin
`ifdef ONEWIRE_TX_PRESENCE_CHECK_EN
          if ((r_cnt == CNT_W'(PRES_SAMPLE)) && r_sync[1]) begin
            r_no_presence <= 1'b1;
            r_done        <= 1'b1;
            r_cnt         <= '0;
            r_state       <= ST_DONE;
          end else
`endif
          if (r_cnt == C_RST_HIGH_END) begin
            // First slot starts low straight away
            r_cnt       <= '0;
            r_bit       <= '0;
            r_drive_low <= 1'b1;
            r_state     <= ST_SLOT;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end

        ST_SLOT: begin
          if (r_cnt == C_SLOT_END) begin
            r_cnt <= '0;
            if (r_bit == C_FRAME_LAST) begin
              r_drive_low <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_bit       <= r_bit + 1'b1;
              r_drive_low <= 1'b1;
            end
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_drive_low <= (w_cnt_nxt < w_low_len);
          end
        end

        ST_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_drive_low <= 1'b0;
          r_cnt       <= '0;
          r_bit       <= '0;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_drive_low <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus    = r_drive_low ? 1'b0 : 1'bz;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_onewire_tx.sv
// Self-checking bench for onewire_tx: slave presence model, bus pulse decoder and CRC reference model.
// Expectations follow ONEWIRE_TX_PRESENCE_CHECK_EN when the build defines it.
module tb_onewire_tx;

  localparam int T_RST_LOW   = 480;
  localparam int T_RST_START = 57;
  localparam int T_SLOT0     = 947;
  localparam int T_SLOT      = 70;
  localparam int T_DONE      = 5427;
  localparam int T_ABORT     = 57 + 480 + 70 + 1;
  localparam int PRES_LEN    = 120;

  logic        clk = 1'b0;
  logic        reset;
  logic [55:0] i_command;
  logic        i_start;
  wire         bus;
  logic        o_busy;
  logic        o_done;
  logic        o_no_presence;

  int checks   = 0;
  int failures = 0;

  // Frame observation, filled by run_frame
  int   run_len[$];
  int   run_start[$];
  int   done_n;
  logic nopres_at_done;
  logic nopres_at1;
  logic busy_at1;

  // Slave model: presence pulse after a long reset-low
  bit   slave_en;
  logic slave_pull = 1'b0;
  int   s_low   = 0;
  int   s_cnt   = 0;
  int   s_phase = 0;

  onewire_tx dut (
    .clk           (clk),
    .reset         (reset),
    .i_command     (i_command),
    .i_start       (i_start),
    .bus           (bus),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_no_presence (o_no_presence)
  );

  pullup (bus);
  assign bus = slave_pull ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    case (s_phase)
      0: begin
        if (bus === 1'b0) begin
          s_low <= s_low + 1;
        end else begin
          if (s_low >= 400 && slave_en) begin
            s_phase <= 1;
            s_cnt   <= 15;
          end
          s_low <= 0;
        end
      end
      1: begin
        if (s_cnt == 1) begin
          s_phase    <= 2;
          s_cnt      <= PRES_LEN;
          slave_pull <= 1'b1;
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end
      default: begin
        if (s_cnt == 1) begin
          s_phase    <= 0;
          slave_pull <= 1'b0;
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end
    endcase
  end

  // Dallas CRC-8 computed byte by byte, LSB first
  function automatic logic [7:0] crc_ref(input logic [55:0] c);
    logic [7:0] crc;
    logic [7:0] b;
    crc = 8'h00;
    for (int i = 0; i < 7; i++) begin
      b = c[8*i +: 8];
      for (int j = 0; j < 8; j++) begin
        if ((crc[0] ^ b[0]) == 1'b1) crc = (crc >> 1) ^ 8'h8C;
        else                         crc = crc >> 1;
        b = b >> 1;
      end
    end
    return crc;
  endfunction

  function automatic logic [63:0] frame_of(input logic [55:0] c);
    return {crc_ref(c), c};
  endfunction

  // Number of write slots whose low length or start time differs from the frame
  function automatic int count_bad(input logic [63:0] fr, input int first);
    int bad;
    int want;
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      want = fr[k] ? 6 : 60;
      if (first + k >= run_len.size()) bad++;
      else if (run_len[first+k] != want || run_start[first+k] != T_SLOT0 + T_SLOT * k) bad++;
    end
    return bad;
  endfunction

  function automatic logic [55:0] rand_cmd();
    return {24'($urandom), 32'($urandom)};
  endfunction

  // Starts a frame and records bus low runs until o_done, stop_at or max_n
  task automatic run_frame(input logic [55:0] cmd, input int max_n, input bit disturb,
                           input int stop_at);
    int n;
    int run;
    int rs;
    run_len.delete();
    run_start.delete();
    done_n         = 0;
    nopres_at_done = 1'bx;
    run            = 0;
    rs             = 0;
    i_command      = cmd;
    i_start        = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
    n          = 1;
    busy_at1   = o_busy;
    nopres_at1 = o_no_presence;
    while (n <= max_n) begin
      if (disturb) begin
        i_start = (n == 100 || n == 2000);
        if (n == 300)  i_command = ~cmd;
        if (n == 3000) i_command = rand_cmd();
      end
      if (bus === 1'b0) begin
        if (run == 0) rs = n;
        run++;
      end else if (run > 0) begin
        run_len.push_back(run);
        run_start.push_back(rs);
        run = 0;
      end
      if (o_done === 1'b1) begin
        done_n         = n;
        nopres_at_done = o_no_presence;
        break;
      end
      if (n == stop_at) break;
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    checks++;
    if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", o_done); end
    checks++;
    if (o_no_presence !== 1'b0) begin failures++; $display("FAIL reset_nopres got=%b want=0", o_no_presence); end
    checks++;
    if (bus !== 1'b1) begin failures++; $display("FAIL reset_bus got=%b want=1", bus); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_cmd();
    int bad;
    slave_en = 1'b1;
    run_frame(56'h0, 6000, 1'b0, 0);
    checks++;
    if (busy_at1 !== 1'b1) begin failures++; $display("FAIL zero_busy_after_start got=%b want=1", busy_at1); end
    checks++;
    if (done_n != T_DONE) begin failures++; $display("FAIL zero_done_cycle got=%0d want=%0d", done_n, T_DONE); end
    checks++;
    if (nopres_at_done !== 1'b0) begin failures++; $display("FAIL zero_nopres got=%b want=0", nopres_at_done); end
    checks++;
    if (run_len.size() != 66 || run_len[0] != T_RST_LOW || run_start[0] != T_RST_START) begin
      failures++;
      $display("FAIL zero_reset_pulse runs=%0d want=66 (reset pulse 480 at 57)", run_len.size());
    end
    bad = count_bad(64'h0, 2);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL zero_slots bad_slots=%0d want=0", bad); end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL zero_idle_after_done busy=%b done=%b want=0/0", o_busy, o_done);
    end
  endtask

  task automatic test_known_vector();
    logic [55:0] cmd;
    int bad;
    cmd = 56'h00000001B81C02;
    slave_en = 1'b1;
    run_frame(cmd, 6000, 1'b0, 0);
    checks++;
    if (done_n != T_DONE) begin failures++; $display("FAIL vec_done_cycle got=%0d want=%0d", done_n, T_DONE); end
    bad = count_bad({8'hA2, cmd}, 2);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL vec_frame_crc_a2 bad_slots=%0d want=0", bad); end
    @(negedge clk);
  endtask

  task automatic test_no_slave();
    logic [55:0] cmd;
    cmd = rand_cmd();
    slave_en = 1'b0;
    run_frame(cmd, 6000, 1'b0, 0);
`ifdef ONEWIRE_TX_PRESENCE_CHECK_EN
    checks++;
    if (done_n != T_ABORT) begin failures++; $display("FAIL nopres_done_cycle got=%0d want=%0d", done_n, T_ABORT); end
    checks++;
    if (nopres_at_done !== 1'b1) begin failures++; $display("FAIL nopres_flag got=%b want=1", nopres_at_done); end
    checks++;
    if (run_len.size() != 1) begin failures++; $display("FAIL nopres_no_slots runs=%0d want=1", run_len.size()); end
    @(negedge clk);
    checks++;
    if (o_no_presence !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL nopres_hold nopres=%b busy=%b want=1/0", o_no_presence, o_busy);
    end
`else
    checks++;
    if (done_n != T_DONE) begin failures++; $display("FAIL noslave_done_cycle got=%0d want=%0d", done_n, T_DONE); end
    checks++;
    if (nopres_at_done !== 1'b0) begin failures++; $display("FAIL noslave_nopres got=%b want=0", nopres_at_done); end
    checks++;
    if (count_bad(frame_of(cmd), 1) != 0 || run_len.size() != 65) begin
      failures++;
      $display("FAIL noslave_slots runs=%0d want=65", run_len.size());
    end
    @(negedge clk);
`endif
    slave_en = 1'b1;
  endtask

  task automatic test_random();
    logic [55:0] cmd;
    int bad;
    slave_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cmd = rand_cmd();
      run_frame(cmd, 6000, 1'b0, 0);
      checks++;
      if (nopres_at1 !== 1'b0) begin failures++; $display("FAIL rand_nopres_cleared got=%b want=0", nopres_at1); end
      checks++;
      if (done_n != T_DONE) begin failures++; $display("FAIL rand_done_cycle got=%0d want=%0d", done_n, T_DONE); end
      bad = count_bad(frame_of(cmd), 2);
      checks++;
      if (bad != 0) begin failures++; $display("FAIL rand_frame cmd=%h bad_slots=%0d want=0", cmd, bad); end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    logic [55:0] cmd;
    int bad;
    cmd = rand_cmd();
    run_frame(cmd, 6000, 1'b1, 0);
    checks++;
    if (done_n != T_DONE) begin failures++; $display("FAIL busy_done_cycle got=%0d want=%0d", done_n, T_DONE); end
    bad = count_bad(frame_of(cmd), 2);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL busy_latched_frame bad_slots=%0d want=0", bad); end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL busy_no_restart got=%b want=0", o_busy); end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    int bad;
    run_frame(56'h0, 6000, 1'b0, T_SLOT0 + T_SLOT * 20 + 10);
    checks++;
    if (bus !== 1'b0) begin failures++; $display("FAIL rstmid_slot_low got=%b want=0", bus); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_release bus=%b busy=%b done=%b want=1/0/0", bus, o_busy, o_done);
    end
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (o_done === 1'b1) seen_done = 1'b1;
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (o_done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b want=0", seen_done); end
    run_frame(56'h0, 6000, 1'b0, 0);
    checks++;
    if (done_n != T_DONE) begin failures++; $display("FAIL rstmid_restart_done got=%0d want=%0d", done_n, T_DONE); end
    bad = count_bad(64'h0, 2);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rstmid_restart_frame bad_slots=%0d want=0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] cmd_a;
    logic [55:0] cmd_b;
    int bad;
    cmd_a = rand_cmd();
    cmd_b = rand_cmd();
    @(negedge clk);
    run_frame(cmd_a, 6000, 1'b0, 0);
    checks++;
    if (done_n != T_DONE) begin failures++; $display("FAIL b2b_first_done got=%0d want=%0d", done_n, T_DONE); end
    // Start raised in the o_done cycle and held into the following idle cycle
    i_start   = 1'b1;
    i_command = cmd_b;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL b2b_start_in_done_ignored busy=%b want=0", o_busy); end
    run_frame(cmd_b, 6000, 1'b0, 0);
    checks++;
    if (busy_at1 !== 1'b1) begin failures++; $display("FAIL b2b_accept_after_gap busy=%b want=1", busy_at1); end
    checks++;
    if (done_n != T_DONE) begin failures++; $display("FAIL b2b_second_done got=%0d want=%0d", done_n, T_DONE); end
    bad = count_bad(frame_of(cmd_b), 2);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_second_frame bad_slots=%0d want=0", bad); end
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    i_start   = 1'b0;
    i_command = '0;
    slave_en  = 1'b1;
    test_reset();
    test_zero_cmd();
    test_known_vector();
    test_no_slave();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onewire_tx.md
# onewire_tx

Master-side 1-Wire frame transmitter and the counterpart of the slave receive path. It accepts a 56-bit command and computes its CRC-8 (Dallas/Maxim). It then issues a bus reset, optionally checks for a presence pulse, and serializes the 64-bit frame as open-drain write slots. It sits in the master between command generation and the shared `bus` pin.

## Interface
- `RESET_LOW`, 480: cycles the bus is held low for the reset pulse.
- `RESET_HIGH`, 410: cycles the bus is released after the reset pulse (recovery window).
- `PRES_SAMPLE`, 70: cycle within the `RESET_HIGH` window at which presence is sampled.
- `SLOT`, 70: cycles per write slot.
- `LOW1`, 6: low time in cycles for a 1 bit.
- `LOW0`, 60: low time in cycles for a 0 bit.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-low.
- `reset` in 1: synchronous, active-low reset.
- `i_command` in 56: command word, latched when a start is accepted.
- `i_start` in 1: start request, sampled only in IDLE.
- `bus` inout 1: open-drain line, driven 0 or z only.
- `o_busy` out 1: high from the cycle after a start is accepted until `o_done`.
- `o_done` out 1: one-cycle completion pulse.
- `o_no_presence` out 1: presence-missing flag, valid with `o_done` and held until the next accepted start.

## Operation
- **Frame:** `frame[55:0]` = command, `frame[63:56]` = CRC. Sent LSB first: command bit 0 first, CRC bit 7 last.
- **CRC:** poly x^8+x^5+x^4+1, reflected form, init 0x00, no final XOR, over the 56 command bits LSB first. It must equal the slave `crc8` result for the same command.
- **States:**
  - IDLE: `i_start`=1 latches `i_command`, clears `o_no_presence`, goes to CRC.
  - CRC: 56 cycles, one bit per cycle, then RST_LOW.
  - RST_LOW: drive low for `RESET_LOW` cycles, then RST_HIGH.
  - RST_HIGH: release for `RESET_HIGH` cycles. The synchronized bus is sampled at cycle `PRES_SAMPLE`. Sample = 1 sets `o_no_presence` and goes to DONE; otherwise go to SLOT at window end.
  - SLOT: 64 slots of `SLOT` cycles each. Drive low for `LOW1` or `LOW0` cycles, then release for the remainder. A 6-bit bit counter advances at slot end; after bit 63, go to DONE.
  - DONE: `o_done`=1 for one cycle, return to IDLE.
- **Bus input:** 2-flop synchronizer, reset value 1.
- **Bus drive:** `bus` = drive_low ? 0 : z. It is never driven 1.
- **Busy behaviour:** `i_start` while busy is ignored. Changes on `i_command` after acceptance are ignored.
- **Parameter legality:** `LOW1 < LOW0 < SLOT` and `PRES_SAMPLE < RESET_HIGH`; anything else is illegal. A simulation-only check flags violations.

## Timing
- **Reset values:** state IDLE, `o_busy`=0, `o_done`=0, `o_no_presence`=0, bus released, counters 0.
- **Reset mid-operation:** `reset`=0 at any edge releases the bus at that edge and returns to IDLE. No `o_done` is issued.
- **Start accept:** `i_start` is sampled at edge E0.
  - CRC occupies cycles E0+1..E0+56.
  - Bus low E0+57..E0+536.
  - Released window of 410 cycles follows.
  - Slots begin at E0+947.
  - Nominal `o_done` at E0+5427, i.e. 1+56+890+4480 with defaults.
- **Aborted frame:** on no presence, `o_done` occurs one cycle after the sample cycle. No slot is driven.
- **Back-to-back:** `i_start` high in the `o_done` cycle is not accepted. It is accepted the following cycle in IDLE, giving a minimum gap of 1 idle cycle.

## Configuration
- Macro `ONEWIRE_TX_PRESENCE_CHECK_EN`.
- **Defined:** presence is sampled and aborts as above.
- **Undefined:** no sampling. RST_HIGH always runs its full window and proceeds to SLOT, and `o_no_presence` is tied 0.

## Structure
- **Shared package `onewire_pkg`:**
  - Frame width 64, command width 56, CRC width 8.
  - CRC polynomial constant 8'h8C (reflected).
  - State enum.
  - Default timing constants, also used by the slave sampler.
- **Sub-module `onewire_crc8_serial`:** one bit per cycle, with enable and clear, 8-bit result. It is reusable by other serial paths.

## Test plan
- Command 56'h0 with slave model present → CRC 0x00, 64 slots each 60 cycles low, `o_done` at E0+5427, `o_no_presence`=0.
- Command 56'h00000001B81C02 → CRC 0xA2. The slave `onewire_rx` decodes the same command with `o_error`=0.
- No slave (bus pulled up) with the macro defined → `o_done` at E0+57+480+70+1, `o_no_presence`=1, no slot low pulses.
- Same as the previous case with the macro undefined → full 64 slots sent, `o_no_presence`=0.
- `reset`=0 during slot 20 → bus released at that edge, `o_busy`=0, no `o_done`. A new start afterwards completes normally.
- `i_start` pulsed while busy, and `i_command` changed mid-frame → ignored, and the transmitted frame matches the latched command.
